// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: interval state encoding and
// the phase-index width helper used to size ports.
package traffic_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

  function automatic int phase_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Interval counter: restarts at q=0, latches its duration on the first cycle of
// each interval, can be frozen, and flags the last cycle of the interval.
module interval_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  input  logic             hold_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic [CNT_W-1:0] q_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic             start_q, start_d;

  // dur_i is only looked at on the first cycle of an interval; later changes are ignored.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    dur_d   = start_q ? dur_i : dur_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    if (dur_d == '0) dur_d = CNT_W'(1);
    done_o = (cnt_q == dur_d - CNT_W'(1));
    if (restart_i) begin
      cnt_d   = '0;
      start_d = 1'b1;
    end else if (!hold_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      cnt_q   <= '0;
      dur_q   <= CNT_W'(1);
      start_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      start_q <= start_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-approach round-robin intersection controller with emergency preempt and
// flashing-yellow fault mode; lamps decode purely from registered state.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_APPROACHES = 4,
  parameter  int CNT_W          = 32,
  parameter  int FLASH_HALF     = 8,
  localparam int PHASE_W        = phase_width(NUM_APPROACHES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_APPROACHES*CNT_W-1:0] green_time,
  input  logic [CNT_W-1:0]            yellow_time,
  input  logic [CNT_W-1:0]            allred_time,
  input  logic                        preempt,
  input  logic [PHASE_W-1:0]          preempt_dir,
  input  logic                        flash,
  output logic [CNT_W-1:0]            q,
  output logic [PHASE_W-1:0]          phase,
  output logic [STATE_W-1:0]          state,
  output logic [NUM_APPROACHES-1:0]   green,
  output logic [NUM_APPROACHES-1:0]   yellow,
  output logic [NUM_APPROACHES-1:0]   red
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_next;
  logic               blink_q, blink_d;
  logic               restart, hold, tmr_done, pre_valid;
  logic [CNT_W-1:0]   dur_sel;

  assign pre_valid  = preempt && ({1'b0, preempt_dir} < (PHASE_W+1)'(NUM_APPROACHES));
  assign phase_next = (phase_q == PHASE_W'(NUM_APPROACHES - 1)) ? '0 : phase_q + PHASE_W'(1);

  always_comb begin
    dur_sel = allred_time;
    case (state_q)
      ST_GREEN:  dur_sel = green_time[int'(phase_q)*CNT_W +: CNT_W];
      ST_YELLOW: dur_sel = yellow_time;
      ST_FLASH:  dur_sel = CNT_W'(FLASH_HALF);
      default:   dur_sel = allred_time;
    endcase
  end

  interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .restart_i (restart),
    .hold_i    (hold),
    .dur_i     (dur_sel),
    .q_o       (q),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ALLRED;
      phase_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  // Flash overrides everything; preempt only steers the normal sequence.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    blink_d = blink_q;
    restart = 1'b0;
    hold    = 1'b0;
    if (flash) begin
      if (state_q != ST_FLASH) begin
        state_d = ST_FLASH;
        blink_d = 1'b1;
        restart = 1'b1;
      end else if (tmr_done) begin
        blink_d = ~blink_q;
        restart = 1'b1;
      end
    end else begin
      case (state_q)
        ST_FLASH: begin
          state_d = ST_ALLRED;
          phase_d = '0;
          restart = 1'b1;
        end
        ST_ALLRED: if (tmr_done) begin
          state_d = ST_GREEN;
          restart = 1'b1;
          if (pre_valid) phase_d = preempt_dir;
        end
        ST_GREEN: begin
          if (pre_valid && preempt_dir == phase_q) begin
            hold = 1'b1;
          end else if (pre_valid || tmr_done) begin
            state_d = ST_YELLOW;
            restart = 1'b1;
          end
        end
        ST_YELLOW: if (tmr_done) begin
          state_d = ST_ALLRED;
          phase_d = phase_next;
          restart = 1'b1;
        end
        default: state_d = ST_ALLRED;
      endcase
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '0;
    case (state_q)
      ST_GREEN: begin
        red            = '1;
        red[phase_q]   = 1'b0;
        green[phase_q] = 1'b1;
      end
      ST_YELLOW: begin
        red             = '1;
        red[phase_q]    = 1'b0;
        yellow[phase_q] = 1'b1;
      end
      ST_FLASH: yellow = {NUM_APPROACHES{blink_q}};
      default:  red = '1;
    endcase
  end

  assign phase = phase_q;
  assign state = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: a rule-level model checked every cycle,
// plus hand-computed cycle-by-cycle expectations for the directed scenarios.
module tb_traffic_intersection_ctrl;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int FH = 8;
  localparam int PW = 2;
  localparam int S_AR = 0, S_G = 1, S_Y = 2, S_F = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N*CW-1:0] green_time;
  logic [CW-1:0]   yellow_time, allred_time;
  logic            preempt = 1'b0;
  logic [PW-1:0]   preempt_dir = '0;
  logic            flash = 1'b0;
  logic [CW-1:0]   q;
  logic [PW-1:0]   phase;
  logic [1:0]      state;
  logic [N-1:0]    green, yellow, red;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  int cyc     = 0;

  // Model of the spec rules: interval kind, owning approach, elapsed count, latched length.
  int m_state, m_phase, m_q, m_dur;
  bit m_first, m_blink;
  logic [N-1:0] e_g, e_y, e_r;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(.NUM_APPROACHES(N), .CNT_W(CW), .FLASH_HALF(FH)) dut (
    .clk         (clk),
    .reset       (reset),
    .green_time  (green_time),
    .yellow_time (yellow_time),
    .allred_time (allred_time),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .flash       (flash),
    .q           (q),
    .phase       (phase),
    .state       (state),
    .green       (green),
    .yellow      (yellow),
    .red         (red)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int interval_len();
    int d;
    case (m_state)
      S_AR:    d = int'(allred_time);
      S_G:     d = int'(green_time[m_phase*CW +: CW]);
      S_Y:     d = int'(yellow_time);
      default: d = FH;
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  task automatic enter(input int s);
    m_state = s;
    m_q     = 0;
    m_first = 1'b1;
  endtask

  task automatic advance();
    m_q++;
    m_first = 1'b0;
  endtask

  task automatic model_step();
    bit pv, last;
    pv = preempt && (int'(preempt_dir) < N);
    if (m_first) m_dur = interval_len();
    last = (m_q == m_dur - 1);
    if (flash) begin
      if (m_state != S_F) begin
        enter(S_F);
        m_blink = 1'b1;
      end else if (last) begin
        enter(S_F);
        m_blink = ~m_blink;
      end else advance();
    end else if (m_state == S_F) begin
      m_phase = 0;
      enter(S_AR);
    end else if (m_state == S_AR) begin
      if (last) begin
        if (pv) m_phase = int'(preempt_dir);
        enter(S_G);
      end else advance();
    end else if (m_state == S_G) begin
      if (pv && int'(preempt_dir) == m_phase) m_first = 1'b0;
      else if (pv || last) enter(S_Y);
      else advance();
    end else begin
      if (last) begin
        m_phase = (m_phase + 1) % N;
        enter(S_AR);
      end else advance();
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = S_AR; m_phase = 0; m_q = 0; m_dur = 1; m_first = 1'b1; m_blink = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset) begin
      for (int i = 0; i < N; i++) begin
        e_g[i] = (m_state == S_G) && (m_phase == i);
        e_y[i] = ((m_state == S_Y) && (m_phase == i)) || ((m_state == S_F) && m_blink);
        e_r[i] = (m_state == S_AR) || ((m_state == S_G || m_state == S_Y) && m_phase != i);
      end
      check("mdl.state", state, m_state);
      check("mdl.phase", phase, m_phase);
      check("mdl.q", q, m_q);
      check("mdl.green", green, e_g);
      check("mdl.yellow", yellow, e_y);
      check("mdl.red", red, e_r);
      check("inv.one_green", $countones(green) <= 1, 1);
      if (state != 2'd3)
        check("inv.one_lamp", ((green | yellow | red) == {N{1'b1}}) &&
              (((green & yellow) | (green & red) | (yellow & red)) == '0), 1);
    end
  end

  task automatic set_times(input int g0, input int g1, input int g2, input int g3,
                           input int y, input int a);
    green_time[0*CW +: CW] = CW'(g0);
    green_time[1*CW +: CW] = CW'(g1);
    green_time[2*CW +: CW] = CW'(g2);
    green_time[3*CW +: CW] = CW'(g3);
    yellow_time = CW'(y);
    allred_time = CW'(a);
  endtask

  task automatic expect_st(input string tag, input int st, input int ph, input int qq);
    check({tag, ".state"}, state, st);
    check({tag, ".phase"}, phase, ph);
    check({tag, ".q"}, q, qq);
  endtask

  task automatic run_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Reset, then release on a falling edge; "cycle 0" is the sample taken right then.
  task automatic start_seq();
    @(negedge clk);
    reset = 1'b0;
    preempt = 1'b0;
    flash = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  int t1_st[13] = '{0, 1, 1, 2, 2, 0, 1, 1, 1, 2, 2, 0, 1};
  int t1_ph[13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2};
  int t1_q [13] = '{0, 0, 1, 0, 1, 0, 0, 1, 2, 0, 1, 0, 0};

  initial begin
    set_times(2, 3, 4, 5, 2, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_st("rst", 0, 0, 0);
    check("rst.red", red, 4'hf);
    check("rst.green", green, 4'h0);
    check("rst.yellow", yellow, 4'h0);
    cmp_en = 1'b1;

    // Normal round-robin order and the wrap back to approach 0.
    start_seq();
    for (int k = 0; k < 13; k++) begin
      run_to(k);
      expect_st($sformatf("t1c%0d", k), t1_st[k], t1_ph[k], t1_q[k]);
    end
    run_to(26); expect_st("t1c26", 0, 0, 0);
    run_to(27); expect_st("t1c27", 1, 0, 0);

    // Zero durations: every interval is one cycle long.
    set_times(0, 0, 0, 0, 0, 0);
    start_seq();
    for (int k = 0; k < 9; k++) begin
      run_to(k);
      expect_st($sformatf("t2c%0d", k), k % 3, (k / 3) % N, 0);
    end

    // Preempt to another approach from the middle of G0.
    set_times(2, 3, 4, 5, 2, 1);
    start_seq();
    run_to(2); expect_st("t3c2", 1, 0, 1);
    preempt = 1'b1; preempt_dir = 2'd2;
    run_to(3);  expect_st("t3c3", 2, 0, 0);
    run_to(5);  expect_st("t3c5", 0, 1, 0);
    run_to(6);  expect_st("t3c6", 1, 2, 0);
    run_to(10); expect_st("t3c10", 1, 2, 0);
    preempt = 1'b0;
    run_to(13); expect_st("t3c13", 1, 2, 3);
    run_to(14); expect_st("t3c14", 2, 2, 0);
    run_to(16); expect_st("t3c16", 0, 3, 0);
    run_to(17); expect_st("t3c17", 1, 3, 0);

    // Preempt to the approach already green: hold, and a mid-interval length change is ignored.
    start_seq();
    run_to(7); expect_st("t4c7", 1, 1, 1);
    preempt = 1'b1; preempt_dir = 2'd1;
    run_to(12); expect_st("t4c12", 1, 1, 1);
    green_time[1*CW +: CW] = CW'(2);
    run_to(17); expect_st("t4c17", 1, 1, 1);
    preempt = 1'b0;
    run_to(18); expect_st("t4c18", 1, 1, 2);
    run_to(19); expect_st("t4c19", 2, 1, 0);

    // Flash from Y2, with a preempt request that must be ignored.
    set_times(2, 3, 4, 5, 2, 1);
    start_seq();
    run_to(16); expect_st("t5c16", 2, 2, 0);
    flash = 1'b1;
    run_to(17); expect_st("t5c17", 3, 2, 0);
    check("t5c17.yellow", yellow, 4'hf);
    check("t5c17.green", green, 4'h0);
    check("t5c17.red", red, 4'h0);
    run_to(20);
    preempt = 1'b1; preempt_dir = 2'd3;
    run_to(24); expect_st("t5c24", 3, 2, 7); check("t5c24.yellow", yellow, 4'hf);
    run_to(25); expect_st("t5c25", 3, 2, 0); check("t5c25.yellow", yellow, 4'h0);
    run_to(32); expect_st("t5c32", 3, 2, 7); check("t5c32.yellow", yellow, 4'h0);
    flash = 1'b0; preempt = 1'b0;
    run_to(33); expect_st("t5c33", 0, 0, 0); check("t5c33.red", red, 4'hf);
    run_to(34); expect_st("t5c34", 1, 0, 0);

    // Asynchronous reset in the middle of G2.
    start_seq();
    run_to(13); expect_st("t6c13", 1, 2, 1);
    #2 reset = 1'b0;
    #1;
    expect_st("t6rst", 0, 0, 0);
    check("t6rst.red", red, 4'hf);
    check("t6rst.green", green, 4'h0);
    check("t6rst.yellow", yellow, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    run_to(1); expect_st("t6c1", 1, 0, 0);
    run_to(3); expect_st("t6c3", 2, 0, 0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
